vga_fb_ctrl: RTL and testbench

Parametrised VGA display engine. It combines a timing generator with a synchronous-read framebuffer and replaces the fixed 640x480 controller and read-only picture ROM pairing. Additions over that pairing: a runtime write port, optional double buffering with a frame-synchronous bank swap, integer pixel replication (scaling), and a frame_start strobe. It sits between the system write logic (keyboard/CPU) and the board VGA pins.

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_timing.sv | 59 +++++
 rtl/vga_fb_ctrl.sv | 134 +++++++++++++
 tb/tb_vga_fb_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing defaults, helpers and types for the VGA framebuffer display engine.
package vga_pkg;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  function automatic int seg_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} swap_state_e;

  // Per-pixel side-band carried down the display pipeline.
  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic fs;
  } vga_ctrl_t;
endpackage

// File: rtl/vga_timing.sv
// Raster counters plus stage-0 decode of active region, sync pulses and frame start.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int SYNC_POL = 0,
  localparam int H_TOTAL = seg_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL = seg_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic [HW-1:0] h_cnt_o,
  output logic [VW-1:0] v_cnt_o,
  output vga_ctrl_t     ctrl_o,
  output logic          frame_end_o
);
  localparam logic SYNC_LVL = 1'(SYNC_POL != 0);

  logic [HW-1:0] h_cnt_q;
  logic [VW-1:0] v_cnt_q;
  logic          h_last, v_last;

  assign h_last = (int'(h_cnt_q) == H_TOTAL - 1);
  assign v_last = (int'(v_cnt_q) == V_TOTAL - 1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else if (h_last) begin
      h_cnt_q <= '0;
      v_cnt_q <= v_last ? '0 : v_cnt_q + 1'b1;
    end else begin
      h_cnt_q <= h_cnt_q + 1'b1;
    end
  end

  always_comb begin
    ctrl_o.act = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
    ctrl_o.hs  = ((int'(h_cnt_q) >= H_ACTIVE + H_FP) && (int'(h_cnt_q) < H_ACTIVE + H_FP + H_SYNC))
                 ? SYNC_LVL : ~SYNC_LVL;
    ctrl_o.vs  = ((int'(v_cnt_q) >= V_ACTIVE + V_FP) && (int'(v_cnt_q) < V_ACTIVE + V_FP + V_SYNC))
                 ? SYNC_LVL : ~SYNC_LVL;
    ctrl_o.fs  = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  assign h_cnt_o     = h_cnt_q;
  assign v_cnt_o     = v_cnt_q;
  assign frame_end_o = h_last && v_last;
endmodule

// File: rtl/vga_fb_ctrl.sv
// VGA display engine: timing generator, optionally double-buffered framebuffer with
// frame-synchronous bank swap, integer pixel replication, two-cycle output pipeline.
module vga_fb_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int H_FP        = H_FP_DEF,
  parameter int H_SYNC      = H_SYNC_DEF,
  parameter int H_BP        = H_BP_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int V_FP        = V_FP_DEF,
  parameter int V_SYNC      = V_SYNC_DEF,
  parameter int V_BP        = V_BP_DEF,
  parameter int SYNC_POL    = 0,
  parameter int SCALE_SHIFT = 0,
  parameter int COLOR_W     = 8,
  parameter int DOUBLE_BUF  = 1,
  localparam int H_TOTAL    = seg_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL    = seg_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int FB_W       = H_ACTIVE >> SCALE_SHIFT,
  localparam int FB_H       = V_ACTIVE >> SCALE_SHIFT,
  localparam int FB_DEPTH   = FB_W * FB_H,
  localparam int AW         = $clog2(FB_DEPTH),
  localparam int HW         = $clog2(H_TOTAL),
  localparam int VW         = $clog2(V_TOTAL),
  localparam int DW         = 3 * COLOR_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_en_i,
  input  logic [AW-1:0]      wr_addr_i,
  input  logic [DW-1:0]      wr_data_i,
  input  logic               swap_req_i,
  output logic               swap_done_o,
  output logic               frame_start_o,
  output logic [HW-1:0]      h_addr_o,
  output logic [VW-1:0]      v_addr_o,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               valid_o,
  output logic [COLOR_W-1:0] vga_r_o,
  output logic [COLOR_W-1:0] vga_g_o,
  output logic [COLOR_W-1:0] vga_b_o
);
  localparam int        NB       = (DOUBLE_BUF != 0) ? 2 : 1;
  localparam int        MW       = $clog2(NB * FB_DEPTH);
  localparam logic      SYNC_LVL = 1'(SYNC_POL != 0);
  localparam vga_ctrl_t CTRL_RST = '{act: 1'b0, hs: ~SYNC_LVL, vs: ~SYNC_LVL, fs: 1'b0};

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  vga_ctrl_t     ctrl_s0;
  logic          frame_end;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(SYNC_POL)
  ) u_timing (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .h_cnt_o    (h_cnt),
    .v_cnt_o    (v_cnt),
    .ctrl_o     (ctrl_s0),
    .frame_end_o(frame_end)
  );

  swap_state_e state_q;
  logic        disp_bank_q, swap_done_q, swap_req;

  assign swap_req = (DOUBLE_BUF != 0) && swap_req_i;

  // Toggling at the boundary cycle lets the very next read, pixel (0,0), see the new bank.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      disp_bank_q <= 1'b0;
      swap_done_q <= 1'b0;
    end else begin
      swap_done_q <= 1'b0;
      if (frame_end && (state_q == PENDING || swap_req)) begin
        disp_bank_q <= ~disp_bank_q;
        state_q     <= IDLE;
        swap_done_q <= 1'b1;
      end else if (swap_req) begin
        state_q <= PENDING;
      end
    end
  end

  // Banks are stacked in one array; the bank bit selects the upper half.
  logic [DW-1:0] mem_q [NB*FB_DEPTH];
  logic [DW-1:0] rd_data_q;
  logic [MW-1:0] rd_idx, wr_idx;
  logic          wr_bank, wr_ok;

  always_comb begin
    wr_bank = (DOUBLE_BUF != 0) ? ~disp_bank_q : 1'b0;
    wr_ok   = wr_en_i && (int'(wr_addr_i) < FB_DEPTH);
    wr_idx  = MW'(int'(wr_bank) * FB_DEPTH + int'(wr_addr_i));
    rd_idx  = MW'(int'(disp_bank_q) * FB_DEPTH);
    if (ctrl_s0.act)
      rd_idx = MW'(int'(disp_bank_q) * FB_DEPTH + int'(v_cnt >> SCALE_SHIFT) * FB_W
                   + int'(h_cnt >> SCALE_SHIFT));
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_idx] <= wr_data_i;
    rd_data_q <= mem_q[rd_idx];
  end

  vga_ctrl_t [2:1] ctl_q;
  logic [DW-1:0]   rgb_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctl_q <= {CTRL_RST, CTRL_RST};
      rgb_q <= '0;
    end else begin
      ctl_q[1] <= ctrl_s0;
      ctl_q[2] <= ctl_q[1];
      rgb_q    <= ctl_q[1].act ? rd_data_q : '0;
    end
  end

  assign swap_done_o   = swap_done_q;
  assign frame_start_o = ctl_q[2].fs;
  assign h_addr_o      = h_cnt;
  assign v_addr_o      = v_cnt;
  assign hsync_o       = ctl_q[2].hs;
  assign vsync_o       = ctl_q[2].vs;
  assign valid_o       = ctl_q[2].act;
  assign {vga_r_o, vga_g_o, vga_b_o} = rgb_q;
endmodule

// File: tb/tb_vga_fb_ctrl.sv
// Directed bench: a reduced-timing double-buffered instance and a scaled single-bank
// instance with active-high sync, both checked against hand-derived raster values.
module tb_vga_fb_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // u_db: 6x4 visible, H_TOTAL=12, V_TOTAL=8, FB_DEPTH=24, active-low sync
  logic        db_wr_en = 1'b0, db_swap = 1'b0;
  logic [4:0]  db_wr_addr = '0;
  logic [23:0] db_wr_data = '0;
  logic        db_swap_done, db_fs, db_hs, db_vs, db_valid;
  logic [3:0]  db_h;
  logic [2:0]  db_v;
  logic [7:0]  db_r, db_g, db_b;
  logic [23:0] db_rgb;
  assign db_rgb = {db_r, db_g, db_b};

  // u_sc: 12x4 visible, H_TOTAL=20, V_TOTAL=8, scale 2 -> 6x2 framebuffer, active-high sync
  logic        sc_wr_en = 1'b0, sc_swap = 1'b0;
  logic [3:0]  sc_wr_addr = '0;
  logic [23:0] sc_wr_data = '0;
  logic        sc_swap_done, sc_fs, sc_hs, sc_vs, sc_valid;
  logic [4:0]  sc_h;
  logic [2:0]  sc_v;
  logic [7:0]  sc_r, sc_g, sc_b;
  logic [23:0] sc_rgb;
  assign sc_rgb = {sc_r, sc_g, sc_b};

  vga_fb_ctrl #(
    .H_ACTIVE(6), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(0), .SCALE_SHIFT(0), .COLOR_W(8), .DOUBLE_BUF(1)
  ) u_db (
    .clk_i(clk), .rst_i(rst), .wr_en_i(db_wr_en), .wr_addr_i(db_wr_addr),
    .wr_data_i(db_wr_data), .swap_req_i(db_swap), .swap_done_o(db_swap_done),
    .frame_start_o(db_fs), .h_addr_o(db_h), .v_addr_o(db_v), .hsync_o(db_hs),
    .vsync_o(db_vs), .valid_o(db_valid), .vga_r_o(db_r), .vga_g_o(db_g), .vga_b_o(db_b)
  );

  vga_fb_ctrl #(
    .H_ACTIVE(12), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1), .SCALE_SHIFT(1), .COLOR_W(8), .DOUBLE_BUF(0)
  ) u_sc (
    .clk_i(clk), .rst_i(rst), .wr_en_i(sc_wr_en), .wr_addr_i(sc_wr_addr),
    .wr_data_i(sc_wr_data), .swap_req_i(sc_swap), .swap_done_o(sc_swap_done),
    .frame_start_o(sc_fs), .h_addr_o(sc_h), .v_addr_o(sc_v), .hsync_o(sc_hs),
    .vsync_o(sc_vs), .valid_o(sc_valid), .vga_r_o(sc_r), .vga_g_o(sc_g), .vga_b_o(sc_b)
  );

  // Swap pulse tally; db pulses must land while the counters sit at (0,0).
  int db_swaps = 0, db_swap_bad = 0, sc_swaps = 0;
  always @(negedge clk) begin
    if (db_swap_done === 1'b1) begin
      db_swaps++;
      if (db_h != 0 || db_v != 0) db_swap_bad++;
    end
    if (sc_swap_done === 1'b1) sc_swaps++;
  end

  task automatic wait_db(input int h, input int v);
    int n = 0;
    while (!(int'(db_h) == h && int'(db_v) == v) && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (n >= 300) begin errors++; $display("FAIL wait_db_%0d_%0d: counter never reached it", h, v); end
  endtask

  task automatic wait_sc(input int h, input int v);
    int n = 0;
    while (!(int'(sc_h) == h && int'(sc_v) == v) && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (n >= 400) begin errors++; $display("FAIL wait_sc_%0d_%0d: counter never reached it", h, v); end
  endtask

  // Land on the output cycle of pixel (h,v): counters lead outputs by two cycles.
  task automatic pix_db(input int h, input int v);
    wait_db(h, v); repeat (2) @(negedge clk);
  endtask

  task automatic pix_sc(input int h, input int v);
    wait_sc(h, v); repeat (2) @(negedge clk);
  endtask

  task automatic db_wr(input int a, input logic [23:0] d);
    db_wr_en = 1'b1; db_wr_addr = 5'(a); db_wr_data = d;
    @(negedge clk);
    db_wr_en = 1'b0;
  endtask

  task automatic sc_wr(input int a, input logic [23:0] d);
    sc_wr_en = 1'b1; sc_wr_addr = 4'(a); sc_wr_data = d;
    @(negedge clk);
    sc_wr_en = 1'b0;
  endtask

  // Gathers one db frame starting at frame_start: valid count, pixels != want, non-black blanking.
  task automatic scan_db(input logic [23:0] want, output int vcnt, output int bad, output int blank_bad);
    int n = 0;
    vcnt = 0; bad = 0; blank_bad = 0;
    while (db_fs !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (n >= 200) begin errors++; $display("FAIL scan_db_fs: no frame_start seen"); end
    for (int c = 0; c < 96; c++) begin
      if (db_valid === 1'b1) begin vcnt++; if (db_rgb !== want) bad++; end
      else if (db_rgb !== 24'h0) blank_bad++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({db_hs, db_vs, db_valid, db_fs, db_swap_done} !== 5'b11000) begin
      errors++; $display("FAIL reset_db_ctl: got %b want 11000", {db_hs, db_vs, db_valid, db_fs, db_swap_done});
    end
    checks++;
    if (db_rgb !== 24'h0 || db_h !== 4'd0 || db_v !== 3'd0) begin
      errors++; $display("FAIL reset_db_data: rgb %h h %0d v %0d want 0 0 0", db_rgb, db_h, db_v);
    end
    checks++;
    if ({sc_hs, sc_vs, sc_valid, sc_rgb} !== 27'h0) begin
      errors++; $display("FAIL reset_sc: hs %b vs %b valid %b rgb %h want all 0", sc_hs, sc_vs, sc_valid, sc_rgb);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (db_h !== 4'd1 || db_fs !== 1'b0 || db_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release1: h %0d fs %b valid %b want 1 0 0", db_h, db_fs, db_valid);
    end
    @(negedge clk);
    checks++;
    if (db_h !== 4'd2 || db_fs !== 1'b1 || db_valid !== 1'b1 || sc_fs !== 1'b1) begin
      errors++; $display("FAIL reset_release2: h %0d fs %b valid %b sc_fs %b want 2 1 1 1", db_h, db_fs, db_valid, sc_fs);
    end
    // Reset while hsync is low: it must come back inactive and stay so.
    wait_db(11, 0);
    checks++;
    if (db_hs !== 1'b0) begin errors++; $display("FAIL midline_pre_hs: got %b want 0", db_hs); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (db_hs !== 1'b1 || db_valid !== 1'b0 || db_h !== 4'd0 || db_v !== 3'd0 || sc_h !== 5'd0) begin
      errors++; $display("FAIL midline_reset: hs %b valid %b h %0d v %0d sc_h %0d want 1 0 0 0 0", db_hs, db_valid, db_h, db_v, sc_h);
    end
    @(negedge clk);
    checks++;
    if (db_hs !== 1'b1 || db_h !== 4'd1) begin
      errors++; $display("FAIL midline_after1: hs %b h %0d want 1 1", db_hs, db_h);
    end
    @(negedge clk);
    checks++;
    if (db_hs !== 1'b1 || db_fs !== 1'b1) begin
      errors++; $display("FAIL midline_after2: hs %b fs %b want 1 1", db_hs, db_fs);
    end
  endtask

  task automatic test_timing();
    int fall, width, n;
    logic prev;
    wait_db(0, 1);
    prev = db_hs; fall = -1;
    for (int c = 1; c < 30 && fall < 0; c++) begin
      @(negedge clk);
      if (prev === 1'b1 && db_hs === 1'b0) fall = c;
      prev = db_hs;
    end
    width = 0;
    while (db_hs === 1'b0 && width < 40) begin width++; @(negedge clk); end
    checks++;
    if (fall != 10 || width != 3) begin
      errors++; $display("FAIL hsync_timing: start %0d width %0d want 10 3", fall, width);
    end
    wait_db(0, 2);
    n = 0;
    do begin @(negedge clk); n++; end while (db_h !== 4'd0 && n < 50);
    checks++;
    if (n != 12) begin errors++; $display("FAIL line_period: got %0d want 12", n); end
    wait_db(0, 0);
    prev = db_vs; fall = -1;
    for (int c = 1; c < 100 && fall < 0; c++) begin
      @(negedge clk);
      if (prev === 1'b1 && db_vs === 1'b0) fall = c;
      prev = db_vs;
    end
    width = 0;
    while (db_vs === 1'b0 && width < 100) begin width++; @(negedge clk); end
    checks++;
    if (fall != 62 || width != 24) begin
      errors++; $display("FAIL vsync_timing: start %0d width %0d want 62 24", fall, width);
    end
    n = 0;
    while (db_fs !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (db_h !== 4'd2 || db_v !== 3'd0 || db_valid !== 1'b1) begin
      errors++; $display("FAIL fs_align: h %0d v %0d valid %b want 2 0 1", db_h, db_v, db_valid);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (db_fs !== 1'b1 && n < 200);
    checks++;
    if (n != 96) begin errors++; $display("FAIL frame_period: got %0d want 96", n); end
  endtask

  task automatic test_image_swap();
    int s0, n, vcnt, bad, blank_bad;
    for (int a = 0; a < 24; a++)
      db_wr(a, (a == 0) ? 24'hFF0000 : (a == 5) ? 24'h00FF00 : 24'h0A0B0C);
    s0 = db_swaps;
    db_swap = 1'b1; @(negedge clk); db_swap = 1'b0;
    n = 0;
    while (db_swap_done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (n >= 200 || db_h !== 4'd0 || db_v !== 3'd0) begin
      errors++; $display("FAIL swap_done_pos: h %0d v %0d waited %0d want 0 0 <200", db_h, db_v, n);
    end
    pix_db(0, 0);
    checks++;
    if (db_rgb !== 24'hFF0000) begin errors++; $display("FAIL px_first: got %h want ff0000", db_rgb); end
    pix_db(1, 0);
    checks++;
    if (db_rgb !== 24'h0A0B0C) begin errors++; $display("FAIL px_1_0: got %h want 0a0b0c", db_rgb); end
    pix_db(5, 0);
    checks++;
    if (db_rgb !== 24'h00FF00) begin errors++; $display("FAIL px_last: got %h want 00ff00", db_rgb); end
    scan_db(24'h0A0B0C, vcnt, bad, blank_bad);
    checks++;
    if (vcnt != 24 || bad != 2 || blank_bad != 0) begin
      errors++; $display("FAIL frame_scan1: valid %0d other %0d blank_nonzero %0d want 24 2 0", vcnt, bad, blank_bad);
    end
    checks++;
    if (db_swaps - s0 != 1) begin errors++; $display("FAIL swap_count1: got %0d want 1", db_swaps - s0); end
    // Back bank is now bank 0; out-of-range writes must not alias into bank 1.
    db_wr(24, 24'hABCDEF);
    db_wr(31, 24'hABCDEF);
    pix_db(0, 0);
    checks++;
    if (db_rgb !== 24'hFF0000) begin errors++; $display("FAIL oob_px_0_0: got %h want ff0000", db_rgb); end
    pix_db(1, 1);
    checks++;
    if (db_rgb !== 24'h0A0B0C) begin errors++; $display("FAIL oob_px_1_1: got %h want 0a0b0c", db_rgb); end
  endtask

  task automatic test_double_buffer();
    int s0, vcnt, bad, blank_bad;
    for (int a = 0; a < 24; a++) db_wr(a, 24'h123456);
    wait_db(0, 1);
    s0 = db_swaps;
    db_swap = 1'b1; @(negedge clk); db_swap = 1'b0;
    repeat (5) @(negedge clk);
    db_swap = 1'b1; @(negedge clk); db_swap = 1'b0;
    pix_db(0, 3);
    checks++;
    if (db_rgb !== 24'h0A0B0C) begin errors++; $display("FAIL cur_frame_0_3: got %h want 0a0b0c", db_rgb); end
    pix_db(5, 3);
    checks++;
    if (db_rgb !== 24'h0A0B0C || db_swaps != s0) begin
      errors++; $display("FAIL cur_frame_5_3: got %h swaps %0d want 0a0b0c 0", db_rgb, db_swaps - s0);
    end
    scan_db(24'h123456, vcnt, bad, blank_bad);
    checks++;
    if (vcnt != 24 || bad != 0 || blank_bad != 0) begin
      errors++; $display("FAIL frame_scan2: valid %0d wrong %0d blank_nonzero %0d want 24 0 0", vcnt, bad, blank_bad);
    end
    checks++;
    if (db_swaps - s0 != 1 || db_swap_bad != 0) begin
      errors++; $display("FAIL swap_once: swaps %0d misplaced %0d want 1 0", db_swaps - s0, db_swap_bad);
    end
  endtask

  task automatic test_boundary_swap();
    int s0;
    s0 = db_swaps;
    wait_db(11, 7);
    checks++;
    if (db_swaps != s0) begin errors++; $display("FAIL no_extra_swap: got %0d want 0", db_swaps - s0); end
    db_swap = 1'b1; @(negedge clk); db_swap = 1'b0;
    checks++;
    if (db_swap_done !== 1'b1 || db_h !== 4'd0 || db_v !== 3'd0) begin
      errors++; $display("FAIL boundary_swap_done: done %b h %0d v %0d want 1 0 0", db_swap_done, db_h, db_v);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (db_rgb !== 24'hFF0000) begin errors++; $display("FAIL boundary_px: got %h want ff0000", db_rgb); end
    wait_db(11, 7); @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (db_rgb !== 24'hFF0000 || db_swaps - s0 != 1) begin
      errors++; $display("FAIL boundary_next: rgb %h swaps %0d want ff0000 1", db_rgb, db_swaps - s0);
    end
  endtask

  task automatic test_scale();
    sc_swap = 1'b1; @(negedge clk); sc_swap = 1'b0;
    sc_wr(0, 24'h111111);
    sc_wr(1, 24'h0000FF);
    sc_wr(6, 24'h222222);
    sc_wr(7, 24'h333333);
    sc_wr(12, 24'hEEEEEE);
    pix_sc(1, 0);
    checks++;
    if (sc_rgb !== 24'h111111) begin errors++; $display("FAIL sc_px_1_0: got %h want 111111", sc_rgb); end
    pix_sc(2, 0);
    checks++;
    if (sc_rgb !== 24'h0000FF) begin errors++; $display("FAIL sc_px_2_0: got %h want 0000ff", sc_rgb); end
    pix_sc(15, 0);
    checks++;
    if (sc_hs !== 1'b1 || sc_valid !== 1'b0 || sc_rgb !== 24'h0) begin
      errors++; $display("FAIL sc_sync: hs %b valid %b rgb %h want 1 0 000000", sc_hs, sc_valid, sc_rgb);
    end
    pix_sc(0, 1);
    checks++;
    if (sc_rgb !== 24'h111111) begin errors++; $display("FAIL sc_px_0_1: got %h want 111111", sc_rgb); end
    pix_sc(3, 1);
    checks++;
    if (sc_rgb !== 24'h0000FF) begin errors++; $display("FAIL sc_px_3_1: got %h want 0000ff", sc_rgb); end
    pix_sc(0, 2);
    checks++;
    if (sc_rgb !== 24'h222222) begin errors++; $display("FAIL sc_px_0_2: got %h want 222222", sc_rgb); end
    pix_sc(3, 3);
    checks++;
    if (sc_rgb !== 24'h333333) begin errors++; $display("FAIL sc_px_3_3: got %h want 333333", sc_rgb); end
  endtask

  task automatic test_rw_collision();
    wait_sc(2, 0);
    sc_wr(1, 24'hFF00FF);
    @(negedge clk);
    checks++;
    if (sc_rgb !== 24'h0000FF) begin errors++; $display("FAIL rw_old: got %h want 0000ff", sc_rgb); end
    @(negedge clk);
    checks++;
    if (sc_rgb !== 24'hFF00FF) begin errors++; $display("FAIL rw_new: got %h want ff00ff", sc_rgb); end
    checks++;
    if (sc_swaps != 0) begin errors++; $display("FAIL sc_swap_ignored: got %0d want 0", sc_swaps); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_image_swap();
    test_double_buffer();
    test_boundary_swap();
    test_scale();
    test_rw_collision();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
